// File: rtl/digit_key_bus_device.sv
// Bus responder for the counter/display demo: ten 7-segment digit registers (RW)
// and a debounced key-state / press-event register (R, clear-on-read events).
module digit_key_bus_device #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_KEYS        = 3
) (
    input  logic                wClk,
    input  logic                wReset,
    input  logic                wWrite,
    input  logic [31:0]         bWriteAddr,
    input  logic [31:0]         bWriteData,
    input  logic [3:0]          bWriteMask,
    input  logic                wRead,
    input  logic [31:0]         bReadAddr,
    output logic [31:0]         bReadData,
    input  logic [NUM_KEYS-1:0] wKeyRaw,
    output logic [79:0]         bSegments
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [29:0] WORD_KEYS = 30'h3C00_0000;
    localparam logic [29:0] WORD_DIG0 = 30'h3C00_0004;
    localparam logic [29:0] WORD_DIG1 = 30'h3C00_0005;
    localparam logic [29:0] WORD_DIG2 = 30'h3C00_0006;

    logic [79:0]         segReg;
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] pressEvt;
    logic [NUM_KEYS-1:0] toggle;
    logic [CW-1:0]       cnt [NUM_KEYS];
    logic [31:0]         readVal;
    logic                wrDig0;
    logic                wrDig1;
    logic                wrDig2;
    logic                rdKeys;
    logic                unusedAddrBits;

    assign unusedAddrBits = ^{bWriteAddr[1:0], bReadAddr[1:0]};

    assign wrDig0 = wWrite && (bWriteAddr[31:2] == WORD_DIG0);
    assign wrDig1 = wWrite && (bWriteAddr[31:2] == WORD_DIG1);
    assign wrDig2 = wWrite && (bWriteAddr[31:2] == WORD_DIG2);
    assign rdKeys = wRead  && (bReadAddr[31:2]  == WORD_KEYS);

    assign bSegments = segReg;

    always_comb begin
        toggle = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            toggle[k] = (sync2[k] != stable[k]) && (cnt[k] == CNT_LAST);
        end
    end

    always_comb begin
        readVal = '0;
        case (bReadAddr[31:2])
            WORD_KEYS: begin
                readVal[NUM_KEYS-1:0]  = stable;
                readVal[8 +: NUM_KEYS] = pressEvt;
            end
            WORD_DIG0: readVal        = segReg[31:0];
            WORD_DIG1: readVal        = segReg[63:32];
            WORD_DIG2: readVal[15:0]  = segReg[79:64];
            default:   readVal        = '0;
        endcase
    end

    always_ff @(posedge wClk) begin
        if (wReset) begin
            segReg <= '0;
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (!bWriteMask[b]) begin
                    if (wrDig0) segReg[8*b +: 8]      <= bWriteData[8*b +: 8];
                    if (wrDig1) segReg[32 + 8*b +: 8] <= bWriteData[8*b +: 8];
                end
            end
            for (int unsigned b = 0; b < 2; b++) begin
                if (!bWriteMask[b] && wrDig2) segReg[64 + 8*b +: 8] <= bWriteData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge wClk) begin
        if (wReset) begin
            bReadData <= '0;
        end else if (wRead) begin
            bReadData <= readVal;
        end
    end

    always_ff @(posedge wClk) begin
        if (wReset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            pressEvt <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
        end else begin
            sync1 <= wKeyRaw;
            sync2 <= sync1;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (sync2[k] == stable[k] || toggle[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
            end
            stable <= stable ^ toggle;
            // An event raised on the same edge as a clearing read must survive it.
            pressEvt <= (rdKeys ? '0 : pressEvt) | (toggle & ~stable);
        end
    end

endmodule

// File: tb/tb_digit_key_bus_device.sv
// Directed bench for digit_key_bus_device: register map, masking, read timing,
// debounce latency, glitch rejection, event clear-on-read and reset behaviour.
module tb_digit_key_bus_device;

    localparam int DB = 16;
    localparam int NK = 3;

    logic          wClk = 1'b0;
    logic          wReset;
    logic          wWrite;
    logic [31:0]   bWriteAddr;
    logic [31:0]   bWriteData;
    logic [3:0]    bWriteMask;
    logic          wRead;
    logic [31:0]   bReadAddr;
    logic [31:0]   bReadData;
    logic [NK-1:0] wKeyRaw;
    logic [79:0]   bSegments;

    int tot = 0;
    int bad = 0;

    digit_key_bus_device #(.DEBOUNCE_CYCLES(DB), .NUM_KEYS(NK)) dut (
        .wClk(wClk), .wReset(wReset), .wWrite(wWrite), .bWriteAddr(bWriteAddr),
        .bWriteData(bWriteData), .bWriteMask(bWriteMask), .wRead(wRead),
        .bReadAddr(bReadAddr), .bReadData(bReadData), .wKeyRaw(wKeyRaw),
        .bSegments(bSegments)
    );

    always #5 wClk = ~wClk;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge wClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        wWrite = 1'b1; bWriteAddr = a; bWriteData = d; bWriteMask = m;
        cyc();
        wWrite = 1'b0;
    endtask

    task automatic doRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
        wRead = 1'b1; bReadAddr = a;
        cyc();
        wRead = 1'b0;
        chk(tag, {48'h0, bReadData}, {48'h0, exp});
    endtask

    initial begin
        wReset = 1'b1; wWrite = 1'b0; bWriteAddr = '0; bWriteData = '0; bWriteMask = '0;
        wRead = 1'b0; bReadAddr = '0; wKeyRaw = '0;
        cyc(2);
        wReset = 1'b0;
        chk("rst_seg", bSegments, 80'h0);
        chk("rst_rd", {48'h0, bReadData}, 80'h0);

        doRead("rd10_rst", 32'hF000_0010, 32'h0);
        doRead("rd14_rst", 32'hF000_0014, 32'h0);
        doRead("rd18_rst", 32'hF000_0018, 32'h0);

        doWrite(32'hF000_0014, 32'h4F5B_063F, 4'b0000);
        doWrite(32'hF000_0018, 32'h0000_6F7F, 4'b1100);
        chk("seg_hi", {48'h0, bSegments[63:32]}, {48'h0, 32'h4F5B_063F});
        chk("seg_top", {64'h0, bSegments[79:64]}, {64'h0, 16'h6F7F});
        doRead("rd18", 32'hF000_0018, 32'h0000_6F7F);
        doWrite(32'hF000_0018, 32'hDEAD_6F7F, 4'b0000);
        doRead("rd18_upper_ign", 32'hF000_0018, 32'h0000_6F7F);

        doWrite(32'hF000_0010, 32'hAABB_CCDD, 4'b1010);
        chk("seg_lo_mask", {48'h0, bSegments[31:0]}, {48'h0, 32'h00BB_00DD});
        doRead("rd10_mask", 32'hF000_0010, 32'h00BB_00DD);
        bReadAddr = 32'hF000_0014;
        cyc();
        chk("rd_hold", {48'h0, bReadData}, {48'h0, 32'h00BB_00DD});
        doRead("rd13_lowbits", 32'hF000_0013, 32'h00BB_00DD);

        doRead("rd_unmap1c", 32'hF000_001C, 32'h0);
        doRead("rd_unmapE", 32'hE000_0010, 32'h0);
        doWrite(32'hF000_0000, 32'hFFFF_FFFF, 4'b0000);
        doWrite(32'hF000_0020, 32'hFFFF_FFFF, 4'b0000);
        chk("wr_ignored", bSegments, {16'h6F7F, 32'h4F5B_063F, 32'h00BB_00DD});

        wWrite = 1'b1; bWriteAddr = 32'hF000_0014; bWriteData = 32'h1122_3344; bWriteMask = '0;
        wRead = 1'b1; bReadAddr = 32'hF000_0014;
        cyc();
        wWrite = 1'b0; wRead = 1'b0;
        chk("rw_same_pre", {48'h0, bReadData}, {48'h0, 32'h4F5B_063F});
        doRead("rw_same_post", 32'hF000_0014, 32'h1122_3344);

        // Key 0: stable flips on the (DB+2)th edge after the raw change.
        wKeyRaw[0] = 1'b1;
        cyc(DB + 1);
        wRead = 1'b1; bReadAddr = 32'hF000_0000;
        cyc();
        chk("key_edge_minus1", {48'h0, bReadData}, 80'h0);
        cyc();
        chk("key_press_evt", {48'h0, bReadData}, {48'h0, 32'h0000_0101});
        cyc();
        wRead = 1'b0;
        chk("key_evt_cleared", {48'h0, bReadData}, {48'h0, 32'h0000_0001});

        wKeyRaw[0] = 1'b0;
        cyc(DB + 4);
        doRead("key_release", 32'hF000_0000, 32'h0);

        wKeyRaw[1] = 1'b1;
        cyc(DB - 2);
        wKeyRaw[1] = 1'b0;
        cyc(DB + 4);
        doRead("glitch_reject", 32'hF000_0000, 32'h0);

        wKeyRaw[2] = 1'b1;
        cyc(DB + 4);
        wReset = 1'b1; wKeyRaw[2] = 1'b0;
        wWrite = 1'b1; bWriteAddr = 32'hF000_0010; bWriteData = 32'hFFFF_FFFF; bWriteMask = '0;
        cyc();
        wReset = 1'b0; wWrite = 1'b0;
        chk("rst_mid_seg", bSegments, 80'h0);
        chk("rst_mid_rd", {48'h0, bReadData}, 80'h0);
        doRead("rst_mid_keys", 32'hF000_0000, 32'h0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
